bin_stream_packer: RTL and testbench

Sink for the 1-bit edge stream (din/din_sop/din_eop/din_vld) produced by the edge-detection stage. Collects binary pixels MSB-first into 16-bit words, marks first and last word of each frame, and presents words on a valid/ready interface toward the SDRAM write FIFO. Upstream has no backpressure, so the block buffers two words and flags overflow. An optional length checker compares each frame's pixel count against the configured geometry.

---
 rtl/bin_pack_pkg.sv | 22 ++
 rtl/bin_pack_fifo2.sv | 56 +++++
 rtl/bin_stream_packer.sv | 123 ++++++++++++
 tb/tb_bin_stream_packer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_pack_pkg.sv
// Shared types and helpers for the binary pixel stream packer.
// Word records use DEF_DATA_W, so the top's DATA_W must match it.
package bin_pack_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } word_t;

  function automatic int frame_pix(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/bin_pack_fifo2.sv
// Two-entry word FIFO; entry 0 is always the head and drives the output port.
module bin_pack_fifo2
  import bin_pack_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t wdata,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output word_t head
);

  word_t      e0, e1;
  logic [1:0] cnt;
  logic       pop_ok, push_ok;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'd2);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);
  assign head    = e0;

  // NOTE: the two entries are reset (cheap here) so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= wdata;
          else             e1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= wdata;
          end else begin
            e0 <= e1;
            e1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bin_stream_packer.sv
// Packs a 1-bit pixel stream MSB-first into DATA_W-bit words with frame flags.
// Optional frame length checking is enabled by defining BIN_PACK_LEN_CHECK_EN.
module bin_stream_packer
  import bin_pack_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              din_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              frame_done,
  output logic              ovf,
  output logic              len_err
);

  localparam int IDX_W = $clog2(DATA_W);

  state_e            state;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic              first;

  logic              load_sop, beat_run, complete;
  logic [DATA_W-1:0] base, merged;
  logic [IDX_W-1:0]  pos;
  word_t             push_word, head;
  logic              full, empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load_sop = din_vld & din_sop;
    beat_run = din_vld & ~din_sop & (state == RUN);
    base     = load_sop ? '0 : acc;
    pos      = load_sop ? '0 : idx;
    merged   = base;
    merged[IDX_W'(DATA_W-1) - pos] = din;
    complete = load_sop ? din_eop
                        : (beat_run & (din_eop | (idx == IDX_W'(DATA_W-1))));
    push_word.data = merged;
    push_word.sop  = load_sop | first;
    push_word.eop  = din_eop;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      first      <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= (load_sop | beat_run) & din_eop;
      if (complete & full & ~dout_rdy) ovf <= 1'b1;
      if (load_sop | beat_run) begin
        if (complete) begin
          acc   <= '0;
          idx   <= '0;
          first <= 1'b0;
        end else begin
          acc   <= merged;
          idx   <= pos + IDX_W'(1);
          first <= load_sop | first;
        end
        state <= din_eop ? IDLE : RUN;
      end
    end
  end

`ifdef BIN_PACK_LEN_CHECK_EN
  localparam int FRAME_PIX = frame_pix(H_ACTIVE, V_ACTIVE);
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);

  logic [CNT_W-1:0] cnt, cnt_next;

  // Count includes the current beat; it saturates rather than wrapping.
  always_comb begin
    cnt_next = load_sop ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      if (load_sop | beat_run) cnt <= cnt_next;
      if ((load_sop & (state == RUN)) |
          ((load_sop | beat_run) & din_eop & (cnt_next != CNT_W'(FRAME_PIX))))
        len_err <= 1'b1;
    end
  end
`else
  assign len_err = 1'b0;
`endif

  bin_pack_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (complete),
    .wdata (push_word),
    .pop   (dout_rdy),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign dout     = head.data;
  assign dout_sop = head.sop;
  assign dout_eop = head.eop;
  assign dout_vld = ~empty;

endmodule

// File: tb/tb_bin_stream_packer.sv
// Randomized and directed bench for bin_stream_packer against a pixel-list reference model.
module tb_bin_stream_packer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int DW = 16;
  localparam int FP = H * V;
`ifdef BIN_PACK_LEN_CHECK_EN
  localparam int LEN_EN = 1;
`else
  localparam int LEN_EN = 0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          din = 1'b0, din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0;
  logic          dout_rdy = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_sop, dout_eop, dout_vld, frame_done, ovf, len_err;

  always #5 clk = ~clk;

  bin_stream_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
    .din_vld(din_vld), .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .frame_done(frame_done),
    .ovf(ovf), .len_err(len_err)
  );

  typedef struct {
    int data;
    bit sop;
    bit eop;
  } exp_word_t;

  exp_word_t q[$];
  int        bits[$];
  bit        in_frame, first_w, m_ovf, m_len, m_fd;
  int        flen;
  int        n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    bits.delete();
    in_frame = 0; first_w = 0; m_ovf = 0; m_len = 0; m_fd = 0; flen = 0;
  endtask

  // Reference: frames are lists of pixels; a word is emitted every DATA_W pixels or at eop.
  task automatic model_step(input bit v, input bit d, input bit s, input bit e, input bit r);
    bit        popped, pushed;
    exp_word_t w;
    popped = r && (q.size() > 0);
    pushed = 0;
    m_fd   = 0;
    if (v) begin
      if (s) begin
        if (in_frame && LEN_EN != 0) m_len = 1;
        bits.delete();
        in_frame = 1; first_w = 1; flen = 0;
      end
      if (in_frame) begin
        bits.push_back(int'(d));
        flen++;
        if (e || bits.size() == DW) begin
          w.data = 0;
          foreach (bits[i]) w.data += bits[i] << (DW - 1 - i);
          w.sop = first_w; w.eop = e;
          first_w = 0;
          bits.delete();
          pushed = 1;
        end
        if (e) begin
          m_fd = 1;
          if (flen != FP && LEN_EN != 0) m_len = 1;
          in_frame = 0;
        end
      end
    end
    if (popped) void'(q.pop_front());
    if (pushed) begin
      if (q.size() < 2) q.push_back(w);
      else              m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("vld", dout_vld, q.size() > 0);
    if (q.size() > 0) begin
      check("data", dout, q[0].data);
      check("sop", dout_sop, q[0].sop);
      check("eop", dout_eop, q[0].eop);
    end
    check("frame_done", frame_done, m_fd);
    check("ovf", ovf, m_ovf);
    check("len_err", len_err, m_len);
  endtask

  task automatic step(input bit v, input bit d, input bit s, input bit e, input bit r);
    din_vld = v; din = d; din_sop = s; din_eop = e; dout_rdy = r;
    model_step(v, d, s, e, r);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    din_vld = 0; din = 0; din_sop = 0; din_eop = 0; dout_rdy = 0;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    compare_all();
    check("rst_dout", {dout, dout_sop, dout_eop}, 0);
    rst_n = 1;
  endtask

  int p1[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  int gen_left;
  bit v, s, e, d, r;

  initial begin
    do_reset();

    // 4x2 frame packed into a single word.
    for (int i = 0; i < 8; i++) step(1, p1[i][0], i == 0, i == 7, 0);
    check("t1_word", dout, 16'hB200);
    check("t1_flags", {dout_sop, dout_eop}, 2'b11);
    check("t1_fd", frame_done, 1);
    check("t1_len", len_err, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Long alternating frame streamed with ready held high.
    for (int i = 0; i < 64; i++) step(1, (i % 2) == 0, i == 0, i == 63, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    do_reset();

    // Same pattern with ready low: third completed word overflows.
    for (int i = 0; i < 48; i++) step(1, (i % 2) == 0, i == 0, i == 47, 0);
    check("t3_ovf", ovf, 1);
    check("t3_head", dout, 16'hAAAA);
    check("t3_head_sop", dout_sop, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    do_reset();

    // 17 ones: full word then one-pixel tail.
    for (int i = 0; i < 17; i++) begin
      step(1, 1, i == 0, i == 16, 1);
      if (i == 15) check("t4_full", {dout, dout_sop, dout_eop}, {16'hFFFF, 2'b10});
    end
    check("t4_tail", {dout, dout_sop, dout_eop}, {16'h8000, 2'b01});
    check("t4_len", len_err, LEN_EN);
    step(0, 0, 0, 0, 1);
    do_reset();

    // Restart with sop at the fifth RUN pixel.
    for (int i = 0; i < 5; i++) step(1, 1, i == 0, 0, 1);
    step(1, 1, 1, 0, 1);
    check("t5_nopush", dout_vld, 0);
    check("t5_len", len_err, LEN_EN);
    for (int i = 1; i < 8; i++) step(1, p1[i][0], 0, i == 7, 1);
    check("t5_word", {dout, dout_sop, dout_eop}, {16'hB200, 2'b11});
    step(0, 0, 0, 0, 1);
    do_reset();

    // Reset at pixel 10, then a fresh frame.
    for (int i = 0; i < 10; i++) step(1, 1, i == 0, 0, 1);
    do_reset();
    check("t6_clean", dout_vld, 0);
    for (int i = 0; i < 8; i++) step(1, p1[i][0], i == 0, i == 7, 0);
    check("t6_word", {dout, dout_sop, dout_eop}, {16'hB200, 2'b11});
    check("t6_len", len_err, 0);
    step(0, 0, 0, 0, 1);
    do_reset();

    // Random frames, gaps, restarts and backpressure.
    gen_left = 0;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom % 4) != 0;
      d = $urandom % 2;
      r = ($urandom % 10) < 7;
      s = 0; e = 0;
      if (v) begin
        if (gen_left == 0 && ($urandom % 4) == 0) begin
          s = 0;
        end else begin
          if (gen_left == 0 || ($urandom % 64) == 0) begin
            s = 1;
            gen_left = (($urandom % 3) == 0) ? FP : int'($urandom_range(1, 40));
          end
          e = (gen_left == 1);
          gen_left--;
        end
      end
      step(v, d, s, e, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
